// File: rtl/song_recorder.sv
// Records live keyboard notes into a terminated song image (note/duration/octave per slot),
// with durations quantised to TICK-cycle units. The image matches the song-library encoding.
module song_recorder #(
    parameter int TICK     = 10_000_000,
    parameter int SONG_LEN = 56,
    parameter int LW       = $clog2(SONG_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  record_en,
    input  logic [3:0]            note_in,
    input  logic [1:0]            octave_in,
    output logic [SONG_LEN*4-1:0] song_packed,
    output logic [SONG_LEN*4-1:0] dur_packed,
    output logic [SONG_LEN*2-1:0] oct_packed,
    output logic [LW-1:0]         length,
    output logic                  recording,
    output logic                  done,
    output logic                  full
);
    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int IW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam logic [3:0]    END_MARK  = 4'hF;
    localparam logic [3:0]    MAX_UNITS = 4'd15;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
    localparam logic [LW-1:0] LAST_IDX  = LW'(SONG_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t        state;
    logic          record_q;
    logic [3:0]    note_mem [SONG_LEN];
    logic [3:0]    dur_mem  [SONG_LEN];
    logic [1:0]    oct_mem  [SONG_LEN];
    logic [LW-1:0] wr_idx;
    logic [3:0]    cur_note;
    logic [1:0]    cur_oct;
    logic [TW-1:0] tick;
    logic [3:0]    units;

    logic          rise, fall, wrap, note_chg, sat, commit, last_commit;
    logic [3:0]    units_n, dur_w;
    logic [IW-1:0] wr_ptr, nxt_ptr;

    assign rise    = record_en & ~record_q;
    assign fall    = ~record_en & record_q;
    assign wr_ptr  = wr_idx[IW-1:0];
    assign nxt_ptr = wr_ptr + IW'(1);
    assign length  = wr_idx;

    // units_n already counts a tick wrapping this cycle, so a commit sees the full duration.
    always_comb begin
        wrap     = (tick == TICK_LAST);
        units_n  = units;
        if (wrap && units != MAX_UNITS)
            units_n = units + 4'd1;
        dur_w    = (units_n == 4'd0) ? 4'd1 : units_n;
        note_chg = (note_in != cur_note);
        sat      = wrap && (units_n == MAX_UNITS);
        commit   = 1'b0;
        if (state == S_CAPTURE)
            commit = fall ? (cur_note != 4'd0) : (note_chg || sat);
        last_commit = ((wr_idx + LW'(1)) == LAST_IDX);
    end

    for (genvar g = 0; g < SONG_LEN; g++) begin : g_pack
        assign song_packed[4*g +: 4] = note_mem[g];
        assign dur_packed[4*g +: 4]  = dur_mem[g];
        assign oct_packed[2*g +: 2]  = oct_mem[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            record_q  <= 1'b0;
            wr_idx    <= '0;
            cur_note  <= 4'd0;
            cur_oct   <= 2'd0;
            tick      <= '0;
            units     <= 4'd0;
            recording <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            for (int i = 0; i < SONG_LEN; i++) begin
                note_mem[i] <= (i == 0) ? END_MARK : 4'd0;
                dur_mem[i]  <= 4'd0;
                oct_mem[i]  <= 2'd0;
            end
        end else begin
            record_q <= record_en;
            full     <= 1'b0;

            // Each commit also moves the end marker forward so the image stays terminated.
            if (commit) begin
                note_mem[wr_ptr]  <= cur_note;
                dur_mem[wr_ptr]   <= dur_w;
                oct_mem[wr_ptr]   <= cur_oct;
                note_mem[nxt_ptr] <= END_MARK;
                wr_idx            <= wr_idx + LW'(1);
                full              <= last_commit;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (rise) begin
                        for (int i = 0; i < SONG_LEN; i++) begin
                            note_mem[i] <= (i == 0) ? END_MARK : 4'd0;
                            dur_mem[i]  <= 4'd0;
                            oct_mem[i]  <= 2'd0;
                        end
                        wr_idx    <= '0;
                        state     <= S_ARMED;
                        recording <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (fall) begin
                        state     <= S_DONE;
                        recording <= 1'b0;
                        done      <= 1'b1;
                    end else if (note_in != 4'd0) begin
                        cur_note <= note_in;
                        cur_oct  <= octave_in;
                        tick     <= '0;
                        units    <= 4'd0;
                        state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    tick  <= wrap ? '0 : tick + TW'(1);
                    units <= sat ? 4'd0 : units_n;
                    if (fall || (commit && last_commit)) begin
                        state     <= S_DONE;
                        recording <= 1'b0;
                        done      <= 1'b1;
                    end else if (note_chg) begin
                        cur_note <= note_in;
                        cur_oct  <= octave_in;
                        tick     <= '0;
                        units    <= 4'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: per-cycle note sequences are turned into an expected song image by a
// run-length reference model; a monitor compares the image whenever done rises.
module tb_song_recorder;
    localparam int TICK = 4;
    localparam int SL   = 8;
    localparam int LW   = $clog2(SL + 1);
    localparam logic [SL*4-1:0] RESET_SONG = {{(SL*4-4){1'b0}}, 4'hF};

    typedef struct packed {
        logic [SL*4-1:0] song;
        logic [SL*4-1:0] dur;
        logic [SL*2-1:0] oct;
        logic [LW-1:0]   len;
        logic            full;
    } img_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            record_en;
    logic [3:0]      note_in;
    logic [1:0]      octave_in;
    logic [SL*4-1:0] song_packed;
    logic [SL*4-1:0] dur_packed;
    logic [SL*2-1:0] oct_packed;
    logic [LW-1:0]   length;
    logic            recording;
    logic            done;
    logic            full;

    img_t exp_q[$];
    img_t last_exp;
    int   st_note[$];
    int   st_oct[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic mon_done_q = 1'b0;
    logic mon_rec_q  = 1'b0;
    int   full_cnt   = 0;

    song_recorder #(.TICK(TICK), .SONG_LEN(SL)) dut (
        .clk(clk), .reset(reset), .record_en(record_en), .note_in(note_in),
        .octave_in(octave_in), .song_packed(song_packed), .dur_packed(dur_packed),
        .oct_packed(oct_packed), .length(length), .recording(recording),
        .done(done), .full(full)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected image from the note seen at each clock edge (edge 0 = rise, edge f = fall).
    function automatic img_t model(input int f);
        img_t r;
        int cnt, s, c, len, ks, rem;
        int dur_q[$];
        r.song = RESET_SONG;
        r.dur  = '0;
        r.oct  = '0;
        cnt    = 0;
        s      = 1;
        while (s < f && st_note[s] == 0) s++;
        while (s < f && cnt < SL - 1) begin
            c = s + 1;
            while (c < f && st_note[c] == st_note[s]) c++;
            len = c - s;
            ks  = (len - 1) / (TICK * 15);
            rem = len - ks * TICK * 15;
            dur_q.delete();
            for (int k = 0; k < ks; k++) dur_q.push_back(15);
            if (c < f || st_note[s] != 0)
                dur_q.push_back((rem / TICK == 0) ? 1 : rem / TICK);
            foreach (dur_q[k]) begin
                if (cnt < SL - 1) begin
                    r.song[cnt*4 +: 4] = 4'(st_note[s]);
                    r.dur[cnt*4 +: 4]  = 4'(dur_q[k]);
                    r.oct[cnt*2 +: 2]  = 2'(st_oct[s]);
                    cnt++;
                    r.song[cnt*4 +: 4] = 4'hF;
                end
            end
            s = c;
        end
        r.len  = LW'(cnt);
        r.full = (cnt == SL - 1);
        return r;
    endfunction

    task automatic add_seg(input int note, input int oct, input int cyc);
        repeat (cyc) begin
            st_note.push_back(note);
            st_oct.push_back(oct);
        end
    endtask

    task automatic check_reset_image(input string tag);
        chk({tag, "_song"}, 64'(song_packed), 64'(RESET_SONG));
        chk({tag, "_dur"}, 64'(dur_packed), 64'(0));
        chk({tag, "_oct"}, 64'(oct_packed), 64'(0));
        chk({tag, "_length"}, 64'(length), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_recording"}, 64'(recording), 64'(0));
        chk({tag, "_full"}, 64'(full), 64'(0));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d images pending, done never rose", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("frozen_song", 64'(song_packed), 64'(last_exp.song));
        chk("frozen_length", 64'(length), 64'(last_exp.len));
    endtask

    // Called at a negedge with record_en low; drives one recording session.
    task automatic run_session();
        exp_q.push_back(model(st_note.size()));
        for (int k = 0; k < st_note.size(); k++) begin
            record_en = 1'b1;
            note_in   = 4'(st_note[k]);
            octave_in = 2'(st_oct[k]);
            @(negedge clk);
            if (k == 0) chk("recording_after_rise", 64'(recording), 64'(1));
        end
        record_en = 1'b0;
        note_in   = 4'($urandom_range(0, 7));
        octave_in = 2'($urandom_range(0, 3));
        @(negedge clk);
        drain();
        st_note.delete();
        st_oct.delete();
    endtask

    // monitor / scoreboard
    initial begin
        img_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_done_q = 1'b0;
                mon_rec_q  = 1'b0;
                full_cnt   = 0;
                continue;
            end
            if (recording && !mon_rec_q) full_cnt = 0;
            if (full) full_cnt++;
            if (done && !mon_done_q) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done rose with no expected image queued");
                end else begin
                    e = exp_q.pop_front();
                    chk("song", 64'(song_packed), 64'(e.song));
                    chk("dur", 64'(dur_packed), 64'(e.dur));
                    chk("oct", 64'(oct_packed), 64'(e.oct));
                    chk("length", 64'(length), 64'(e.len));
                    chk("full_pulse", 64'(full_cnt), 64'(e.full));
                    last_exp = e;
                end
            end
            mon_done_q = done;
            mon_rec_q  = recording;
        end
    end

    // stimulus
    initial begin
        int nseg, cyc;
        reset     = 1'b0;
        record_en = 1'b0;
        note_in   = 4'd0;
        octave_in = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_image("por");
        reset = 1'b1;
        @(negedge clk);
        check_reset_image("after_release");

        add_seg(3, 1, 9); add_seg(5, 2, 8);
        run_session();
        add_seg(1, 0, 70);
        run_session();
        for (int i = 0; i < 10; i++) add_seg((i % 2 == 0) ? 1 : 2, i % 4, 4);
        run_session();
        add_seg(0, 0, 10); add_seg(4, 3, 2); add_seg(0, 1, 5);
        run_session();
        for (int i = 0; i < 7; i++) add_seg((i % 2 == 0) ? 1 : 2, 1, 3);
        run_session();
        add_seg(0, 2, 6);
        run_session();

        // reset in the middle of a capture: partial image must vanish
        record_en = 1'b1;
        note_in = 4'd2; octave_in = 2'd1;
        repeat (5) @(negedge clk);
        note_in = 4'd3;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_image("mid_capture_reset");
        record_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        add_seg(6, 2, 4);
        run_session();

        for (int s = 0; s < 40; s++) begin
            nseg = $urandom_range(1, 6);
            for (int j = 0; j < nseg; j++) begin
                cyc = ($urandom_range(0, 7) == 0) ? $urandom_range(55, 75) : $urandom_range(1, 12);
                add_seg($urandom_range(0, 7), $urandom_range(0, 3), cyc);
            end
            run_session();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
